// File: rtl/bias_worker_nw_if.sv
// WCI control-plane and WSI stream signal bundle for bias_worker_nw.
// The slave modport is the worker's view; the master modport is the environment's view.
interface bias_worker_nw_if #(
   parameter int NDW = 1
);
   // WCI control plane
   logic [2:0]        wciS0_MCmd;
   logic              wciS0_MAddrSpace;
   logic [3:0]        wciS0_MByteEn;
   logic [31:0]       wciS0_MAddr;
   logic [31:0]       wciS0_MData;
   logic [1:0]        wciS0_SResp;
   logic [31:0]       wciS0_SData;
   logic              wciS0_SThreadBusy;
   logic [1:0]        wciS0_SFlag;
   logic [1:0]        wciS0_MFlag;
   // WSI input stream
   logic [2:0]        wsiS0_MCmd;
   logic              wsiS0_MReqLast;
   logic              wsiS0_MBurstPrecise;
   logic [11:0]       wsiS0_MBurstLength;
   logic [32*NDW-1:0] wsiS0_MData;
   logic [4*NDW-1:0]  wsiS0_MByteEn;
   logic [7:0]        wsiS0_MReqInfo;
   logic              wsiS0_SThreadBusy;
   logic              wsiS0_SReset_n;
   logic              wsiS0_MReset_n;
   // WSI output stream
   logic [2:0]        wsiM0_MCmd;
   logic              wsiM0_MReqLast;
   logic              wsiM0_MBurstPrecise;
   logic [11:0]       wsiM0_MBurstLength;
   logic [32*NDW-1:0] wsiM0_MData;
   logic [4*NDW-1:0]  wsiM0_MByteEn;
   logic [7:0]        wsiM0_MReqInfo;
   logic              wsiM0_SThreadBusy;
   logic              wsiM0_MReset_n;
   logic              wsiM0_SReset_n;

   modport slave (
      input  wciS0_MCmd, wciS0_MAddrSpace, wciS0_MByteEn, wciS0_MAddr, wciS0_MData, wciS0_MFlag,
      output wciS0_SResp, wciS0_SData, wciS0_SThreadBusy, wciS0_SFlag,
      input  wsiS0_MCmd, wsiS0_MReqLast, wsiS0_MBurstPrecise, wsiS0_MBurstLength,
      input  wsiS0_MData, wsiS0_MByteEn, wsiS0_MReqInfo, wsiS0_MReset_n,
      output wsiS0_SThreadBusy, wsiS0_SReset_n,
      output wsiM0_MCmd, wsiM0_MReqLast, wsiM0_MBurstPrecise, wsiM0_MBurstLength,
      output wsiM0_MData, wsiM0_MByteEn, wsiM0_MReqInfo, wsiM0_MReset_n,
      input  wsiM0_SThreadBusy, wsiM0_SReset_n
   );

   modport master (
      output wciS0_MCmd, wciS0_MAddrSpace, wciS0_MByteEn, wciS0_MAddr, wciS0_MData, wciS0_MFlag,
      input  wciS0_SResp, wciS0_SData, wciS0_SThreadBusy, wciS0_SFlag,
      output wsiS0_MCmd, wsiS0_MReqLast, wsiS0_MBurstPrecise, wsiS0_MBurstLength,
      output wsiS0_MData, wsiS0_MByteEn, wsiS0_MReqInfo, wsiS0_MReset_n,
      input  wsiS0_SThreadBusy, wsiS0_SReset_n,
      input  wsiM0_MCmd, wsiM0_MReqLast, wsiM0_MBurstPrecise, wsiM0_MBurstLength,
      input  wsiM0_MData, wsiM0_MByteEn, wsiM0_MReqInfo, wsiM0_MReset_n,
      output wsiM0_SThreadBusy, wsiM0_SReset_n
   );
endinterface

// File: rtl/bias_worker_nw.sv
// Bias worker: adds a programmable 32-bit bias to every lane of a WSI stream.
// WCI control state machine with bias/ctrl/counter properties, a FIFO between
// input and output, and a held output register honouring downstream backpressure.
module bias_worker_nw #(
   parameter int NDW        = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic            wciS0_Clk,
   input  logic            wciS0_MReset_n,
   bias_worker_nw_if.slave bus
);
   localparam int DW = 32 * NDW;
   localparam int BW = 4 * NDW;
   localparam int EW = DW + BW + 22;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   BUSY_LVL = (AW+1)'(FIFO_DEPTH - 2);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [2:0]    CMD_WR   = 3'd1;
   localparam logic [2:0]    CMD_RD   = 3'd2;
   localparam logic [1:0]    RESP_DVA = 2'd1;
   localparam logic [1:0]    RESP_ERR = 2'd3;

   typedef enum logic [1:0] {
      ST_EXISTS = 2'd0,
      ST_INIT   = 2'd1,
      ST_OPER   = 2'd2,
      ST_SUSP   = 2'd3
   } state_t;

   // Lane add: wrap keeps the low 32 bits, saturate clamps on carry out.
   function automatic logic [31:0] add_lane(input logic [31:0] a, input logic [31:0] b, input logic sat);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (sat && s[32]) add_lane = 32'hFFFF_FFFF;
      else              add_lane = s[31:0];
   endfunction

   state_t        r_state;
   logic [31:0]   r_bias;
   logic          r_mode;
   logic [31:0]   r_msg_cnt;
   logic [31:0]   r_word_cnt;
   logic          r_wci_busy;
   logic [1:0]    r_resp;
   logic [31:0]   r_sdata;
   logic          r_in_busy;
   logic          r_rst_out;
   logic [EW-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          r_ovalid;
   logic [EW-1:0] r_oent;

   logic          w_acc;
   state_t        w_state_nxt;
   logic [1:0]    w_resp;
   logic [31:0]   w_rdata;
   logic          w_release;
   logic          w_bias_wr;
   logic          w_ctrl_wr;
   logic [7:0]    w_off;
   logic [DW-1:0] w_biased;
   logic [EW-1:0] w_in_ent;
   logic          w_push;
   logic          w_pop;
   logic          w_xfer;
   logic          w_unused;

   assign w_acc  = (bus.wciS0_MCmd != 3'd0) && !r_wci_busy;
   assign w_off  = bus.wciS0_MAddr[7:0];
   assign w_xfer = r_ovalid && !bus.wsiM0_SThreadBusy;
   assign w_pop  = (r_count != {(AW+1){1'b0}}) && (!r_ovalid || !bus.wsiM0_SThreadBusy);
   assign w_push = (bus.wsiS0_MCmd == CMD_WR) && (r_state == ST_OPER) && ((r_count != FULL_LVL) || w_pop);

   // Decode an accepted WCI request into response, read data, next state and write strobes.
   always_comb begin
      w_resp      = 2'd0;
      w_rdata     = 32'd0;
      w_state_nxt = r_state;
      w_release   = 1'b0;
      w_bias_wr   = 1'b0;
      w_ctrl_wr   = 1'b0;
      if (!w_acc) begin
         w_resp = 2'd0;
      end else if (!bus.wciS0_MAddrSpace) begin
         if (bus.wciS0_MCmd != CMD_RD) begin
            w_resp = RESP_ERR;
         end else begin
            w_resp = RESP_DVA;
            case (bus.wciS0_MAddr[4:2])
               3'd0: if (r_state == ST_EXISTS) w_state_nxt = ST_INIT; else w_resp = RESP_ERR;
               3'd1: if (r_state == ST_INIT || r_state == ST_SUSP) w_state_nxt = ST_OPER; else w_resp = RESP_ERR;
               3'd2: if (r_state == ST_OPER) w_state_nxt = ST_SUSP; else w_resp = RESP_ERR;
               3'd3: begin
                  if (r_state != ST_EXISTS) begin
                     w_state_nxt = ST_EXISTS;
                     w_release   = 1'b1;
                  end else begin
                     w_resp = RESP_ERR;
                  end
               end
               3'd4, 3'd5, 3'd6: w_resp = RESP_DVA;
               default:          w_resp = RESP_ERR;
            endcase
         end
      end else if (bus.wciS0_MCmd == CMD_WR) begin
         w_resp    = RESP_DVA;
         w_bias_wr = (w_off == 8'h00);
         w_ctrl_wr = (w_off == 8'h04);
      end else if (bus.wciS0_MCmd == CMD_RD) begin
         w_resp = RESP_DVA;
         case (w_off)
            8'h00:   w_rdata = r_bias;
            8'h04:   w_rdata = {31'd0, r_mode};
            8'h08:   w_rdata = r_msg_cnt;
            8'h0C:   w_rdata = r_word_cnt;
            default: w_rdata = 32'd0;
         endcase
      end else begin
         w_resp = RESP_ERR;
      end
   end

   // Apply the bias to every lane as the word enters the buffer.
   always_comb begin
      w_biased = {DW{1'b0}};
      for (int l = 0; l < NDW; l++) begin
         w_biased[32*l +: 32] = add_lane(bus.wsiS0_MData[32*l +: 32], r_bias, r_mode);
      end
   end

   assign w_in_ent = {bus.wsiS0_MReqLast, bus.wsiS0_MBurstPrecise, bus.wsiS0_MBurstLength,
                      bus.wsiS0_MReqInfo, bus.wsiS0_MByteEn, w_biased};

   // WCI handshake, control state, properties, counters and stream-side resets.
   always_ff @(posedge wciS0_Clk or negedge wciS0_MReset_n) begin
      if (!wciS0_MReset_n) begin
         r_state    <= ST_EXISTS;
         r_bias     <= 32'd0;
         r_mode     <= 1'b0;
         r_msg_cnt  <= 32'd0;
         r_word_cnt <= 32'd0;
         r_wci_busy <= 1'b0;
         r_resp     <= 2'd0;
         r_sdata    <= 32'd0;
         r_in_busy  <= 1'b1;
         r_rst_out  <= 1'b0;
      end else begin
         r_rst_out  <= 1'b1;
         r_wci_busy <= w_acc;
         r_resp     <= w_resp;
         r_sdata    <= w_rdata;
         r_state    <= w_state_nxt;
         r_in_busy  <= (r_state != ST_OPER) || (r_count >= BUSY_LVL);
         if (w_bias_wr) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.wciS0_MByteEn[b]) r_bias[8*b +: 8] <= bus.wciS0_MData[8*b +: 8];
            end
         end
         if (w_ctrl_wr) r_mode <= bus.wciS0_MData[0];
         if (w_xfer) begin
            r_word_cnt <= r_word_cnt + 32'd1;
            if (r_oent[EW-1]) r_msg_cnt <= r_msg_cnt + 32'd1;
         end
      end
   end

   // Buffer storage; contents are qualified by the pointers, so no reset is needed.
   always_ff @(posedge wciS0_Clk) begin
      if (w_push) r_mem[r_wptr] <= w_in_ent;
   end

   // Buffer pointers/occupancy and the output register; release discards everything in flight.
   always_ff @(posedge wciS0_Clk or negedge wciS0_MReset_n) begin
      if (!wciS0_MReset_n) begin
         r_wptr   <= {AW{1'b0}};
         r_rptr   <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
         r_ovalid <= 1'b0;
         r_oent   <= {EW{1'b0}};
      end else if (w_release) begin
         r_wptr   <= {AW{1'b0}};
         r_rptr   <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
         r_ovalid <= 1'b0;
         r_oent   <= {EW{1'b0}};
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (w_pop) begin
            r_ovalid <= 1'b1;
            r_oent   <= r_mem[r_rptr];
         end else if (w_xfer) begin
            r_ovalid <= 1'b0;
         end else begin
            r_ovalid <= r_ovalid;
         end
      end
   end

   assign bus.wciS0_SResp       = r_resp;
   assign bus.wciS0_SData       = r_sdata;
   assign bus.wciS0_SThreadBusy = r_wci_busy;
   assign bus.wciS0_SFlag       = 2'b00;
   assign bus.wsiS0_SThreadBusy = r_in_busy;
   assign bus.wsiS0_SReset_n    = r_rst_out;
   assign bus.wsiM0_MReset_n    = r_rst_out;
   assign bus.wsiM0_MCmd        = {2'b00, r_ovalid};
   assign {bus.wsiM0_MReqLast, bus.wsiM0_MBurstPrecise, bus.wsiM0_MBurstLength,
           bus.wsiM0_MReqInfo, bus.wsiM0_MByteEn, bus.wsiM0_MData} = r_oent;

   assign w_unused = ^{bus.wciS0_MFlag, bus.wsiS0_MReset_n, bus.wsiM0_SReset_n, bus.wciS0_MAddr[31:8]};
endmodule

// File: tb/tb_bias_worker_nw.sv
// Directed self-checking bench for bias_worker_nw (two lanes, eight-deep buffer).
module tb_bias_worker_nw;
   localparam int NDW   = 2;
   localparam int DEPTH = 8;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          nchecks = 0;
   int          nerr    = 0;
   logic [64:0] mon_q [$];
   logic [1:0]  wci_resp;
   logic [31:0] wci_data;
   logic        resp_tbusy;
   logic [2:0]  resp_mcmd;

   always #5 clk = ~clk;

   bias_worker_nw_if #(.NDW(NDW)) bus ();

   bias_worker_nw #(.NDW(NDW), .FIFO_DEPTH(DEPTH)) dut (
      .wciS0_Clk      (clk),
      .wciS0_MReset_n (rst_n),
      .bus            (bus)
   );

   // Record every output transfer as {ReqLast, data}.
   always @(negedge clk) begin
      if (rst_n && bus.wsiM0_MCmd == 3'd1 && !bus.wsiM0_SThreadBusy)
         mon_q.push_back({bus.wsiM0_MReqLast, bus.wsiM0_MData});
   end

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wci(input logic [2:0] cmd, input logic sp, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] be);
      int n;
      n = 0;
      bus.wciS0_MCmd       = cmd;
      bus.wciS0_MAddrSpace = sp;
      bus.wciS0_MAddr      = addr;
      bus.wciS0_MData      = data;
      bus.wciS0_MByteEn    = be;
      while (bus.wciS0_SThreadBusy && n < 20) begin
         tick();
         n++;
      end
      tick();
      bus.wciS0_MCmd = 3'd0;
      wci_resp   = bus.wciS0_SResp;
      wci_data   = bus.wciS0_SData;
      resp_tbusy = bus.wciS0_SThreadBusy;
      resp_mcmd  = bus.wsiM0_MCmd;
      chk("wci_accept_bound", 65'(n < 20), 65'd1);
      tick();
   endtask

   task automatic ctl(input logic [2:0] op, input logic [1:0] exp, input string tag);
      wci(3'd2, 1'b0, {27'd0, op, 2'b00}, 32'd0, 4'hF);
      chk(tag, 65'(wci_resp), 65'(exp));
   endtask

   task automatic prop_rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
      wci(3'd2, 1'b1, {24'd0, off}, 32'd0, 4'hF);
      chk({tag, "_resp"}, 65'(wci_resp), 65'd1);
      chk(tag, 65'(wci_data), 65'(exp));
   endtask

   task automatic prop_wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] be, input string tag);
      wci(3'd1, 1'b1, {24'd0, off}, data, be);
      chk(tag, 65'(wci_resp), 65'd1);
   endtask

   task automatic put(input logic [63:0] d, input logic last, input logic [7:0] info, input logic [11:0] blen);
      bus.wsiS0_MCmd          = 3'd1;
      bus.wsiS0_MData         = d;
      bus.wsiS0_MReqLast      = last;
      bus.wsiS0_MReqInfo      = info;
      bus.wsiS0_MBurstLength  = blen;
      bus.wsiS0_MBurstPrecise = 1'b1;
      bus.wsiS0_MByteEn       = 8'h3C;
   endtask

   task automatic idle();
      bus.wsiS0_MCmd = 3'd0;
   endtask

   task automatic wait_q(input int n, input string tag);
      int k;
      k = 0;
      while (mon_q.size() < n && k < 200) begin
         tick();
         k++;
      end
      chk(tag, 65'(mon_q.size()), 65'(n));
   endtask

   // Source honouring wsiS0_SThreadBusy; lanes are base + index.
   task automatic send_words(input logic [31:0] b0, input logic [31:0] b1, input int first,
                             input int cnt, input int last_idx, input string tag);
      int i;
      int k;
      i = first;
      k = 0;
      while (i < first + cnt && k < 200) begin
         if (!bus.wsiS0_SThreadBusy) begin
            put({b1 + 32'(i), b0 + 32'(i)}, (i == last_idx), 8'h11, 12'd6);
            i++;
         end else begin
            idle();
         end
         tick();
         k++;
      end
      idle();
      chk(tag, 65'(i), 65'(first + cnt));
   endtask

   initial begin
      int nin;
      int maxocc;
      int occ;
      logic saw_busy;
      logic [63:0] expd;

      bus.wciS0_MCmd = 3'd0;  bus.wciS0_MAddrSpace = 1'b0; bus.wciS0_MByteEn = 4'hF;
      bus.wciS0_MAddr = 32'd0; bus.wciS0_MData = 32'd0;    bus.wciS0_MFlag = 2'b00;
      bus.wsiS0_MCmd = 3'd0;  bus.wsiS0_MReqLast = 1'b0;   bus.wsiS0_MBurstPrecise = 1'b0;
      bus.wsiS0_MBurstLength = 12'd0; bus.wsiS0_MData = 64'd0; bus.wsiS0_MByteEn = 8'd0;
      bus.wsiS0_MReqInfo = 8'd0; bus.wsiS0_MReset_n = 1'b1;
      bus.wsiM0_SThreadBusy = 1'b0; bus.wsiM0_SReset_n = 1'b1;

      // Reset state
      repeat (3) tick();
      chk("rst_sreset_n",  65'(bus.wsiS0_SReset_n), 65'd0);
      chk("rst_mreset_n",  65'(bus.wsiM0_MReset_n), 65'd0);
      chk("rst_in_busy",   65'(bus.wsiS0_SThreadBusy), 65'd1);
      chk("rst_out_cmd",   65'(bus.wsiM0_MCmd), 65'd0);
      chk("rst_out_data",  65'(bus.wsiM0_MData), 65'd0);
      chk("rst_sresp",     65'(bus.wciS0_SResp), 65'd0);
      chk("rst_wci_busy",  65'(bus.wciS0_SThreadBusy), 65'd0);
      rst_n = 1'b1;
      tick();
      chk("rel_sreset_n",  65'(bus.wsiS0_SReset_n), 65'd1);
      chk("rel_mreset_n",  65'(bus.wsiM0_MReset_n), 65'd1);

      // Properties after reset
      prop_rd(8'h00, 32'd0, "rd_bias0");
      chk("wci_busy_after_accept", 65'(resp_tbusy), 65'd1);
      chk("sresp_null_after", 65'(bus.wciS0_SResp), 65'd0);
      prop_rd(8'h04, 32'd0, "rd_ctrl0");
      prop_rd(8'h08, 32'd0, "rd_msg0");
      prop_rd(8'h0C, 32'd0, "rd_word0");
      chk("idle_in_busy", 65'(bus.wsiS0_SThreadBusy), 65'd1);
      chk("idle_out_cmd", 65'(bus.wsiM0_MCmd), 65'd0);

      // Control state machine
      ctl(3'd1, 2'd3, "start_from_exists");
      ctl(3'd0, 2'd1, "initialize");
      ctl(3'd1, 2'd1, "start");
      ctl(3'd2, 2'd1, "stop");
      ctl(3'd2, 2'd3, "stop_again");
      ctl(3'd7, 2'd3, "op7");
      wci(3'd1, 1'b0, 32'd0, 32'd0, 4'hF);
      chk("wr_ctl_space", 65'(wci_resp), 65'd3);
      ctl(3'd4, 2'd1, "test_op");
      ctl(3'd1, 2'd1, "start_from_susp");
      ctl(3'd0, 2'd3, "init_from_oper");

      // Property writes
      prop_wr(8'h00, 32'hAABB_CCDD, 4'b0010, "wr_bias_be");
      prop_rd(8'h00, 32'h0000_CC00, "rd_bias_be");
      prop_wr(8'h00, 32'h0000_0010, 4'hF, "wr_bias");
      prop_rd(8'h00, 32'h0000_0010, "rd_bias");
      prop_wr(8'h04, 32'h0000_0003, 4'hF, "wr_ctrl3");
      prop_rd(8'h04, 32'h0000_0001, "rd_ctrl1");
      prop_wr(8'h04, 32'h0000_0000, 4'hF, "wr_ctrl0");
      prop_wr(8'h08, 32'h0000_1234, 4'hF, "wr_msg_ro");
      prop_rd(8'h08, 32'd0, "rd_msg_ro");
      prop_rd(8'h40, 32'd0, "rd_other");
      chk("oper_in_busy", 65'(bus.wsiS0_SThreadBusy), 65'd0);

      // Wrap mode, latency and pass-through
      mon_q.delete();
      put({32'h0000_0020, 32'h0000_0001}, 1'b0, 8'h5A, 12'd2);
      tick();
      put({32'h0000_0000, 32'hFFFF_FFF8}, 1'b1, 8'hC3, 12'd2);
      chk("lat_not_yet", 65'(bus.wsiM0_MCmd), 65'd0);
      tick();
      idle();
      chk("lat_cmd", 65'(bus.wsiM0_MCmd), 65'd1);
      chk("wrap_w0", 65'(bus.wsiM0_MData), {1'b0, 32'h0000_0030, 32'h0000_0011});
      chk("w0_last", 65'(bus.wsiM0_MReqLast), 65'd0);
      chk("w0_info", 65'(bus.wsiM0_MReqInfo), 65'h5A);
      chk("w0_byteen", 65'(bus.wsiM0_MByteEn), 65'h3C);
      chk("w0_blen", 65'({bus.wsiM0_MBurstPrecise, bus.wsiM0_MBurstLength}), 65'h1002);
      tick();
      chk("wrap_w1", 65'(bus.wsiM0_MData), {1'b0, 32'h0000_0010, 32'h0000_0008});
      chk("w1_last", 65'(bus.wsiM0_MReqLast), 65'd1);
      chk("w1_info", 65'(bus.wsiM0_MReqInfo), 65'hC3);
      tick();
      chk("lat_drained", 65'(bus.wsiM0_MCmd), 65'd0);
      prop_rd(8'h08, 32'd1, "msg_cnt1");
      prop_rd(8'h0C, 32'd2, "word_cnt2");

      // Saturate mode
      prop_wr(8'h04, 32'h0000_0001, 4'hF, "wr_sat");
      mon_q.delete();
      put({32'h0000_0000, 32'hFFFF_FFF8}, 1'b0, 8'h01, 12'd2);
      tick();
      put({32'h0000_0001, 32'hFFFF_FFFF}, 1'b1, 8'h01, 12'd2);
      tick();
      idle();
      wait_q(2, "sat_count");
      chk("sat_w0", mon_q[0], {1'b0, 32'h0000_0010, 32'hFFFF_FFFF});
      chk("sat_w1", mon_q[1], {1'b1, 32'h0000_0011, 32'hFFFF_FFFF});
      prop_wr(8'h04, 32'h0000_0000, 4'hF, "wr_wrap");

      // Downstream stall for 20 cycles while 30 words stream in
      mon_q.delete();
      nin = 0;
      maxocc = 0;
      saw_busy = 1'b0;
      for (int cyc = 0; cyc < 300 && !(nin == 30 && mon_q.size() == 30); cyc++) begin
         bus.wsiM0_SThreadBusy = (cyc < 20);
         if (bus.wsiS0_SThreadBusy) saw_busy = 1'b1;
         if (!bus.wsiS0_SThreadBusy && nin < 30) begin
            put({32'h2000_0000 + 32'(nin * 7), 32'h0000_0100 + 32'(nin)}, (nin == 29), 8'h22, 12'd30);
            nin++;
         end else begin
            idle();
         end
         tick();
         occ = nin - mon_q.size();
         if (occ > maxocc) maxocc = occ;
      end
      idle();
      bus.wsiM0_SThreadBusy = 1'b0;
      chk("stall_in_count", 65'(nin), 65'd30);
      chk("stall_out_count", 65'(mon_q.size()), 65'd30);
      chk("stall_throttled", 65'(saw_busy), 65'd1);
      chk("stall_occupancy_ok", 65'(maxocc <= DEPTH + 1), 65'd1);
      for (int i = 0; i < 30 && i < mon_q.size(); i++) begin
         expd = {32'h2000_0010 + 32'(i * 7), 32'h0000_0110 + 32'(i)};
         chk($sformatf("stall_w%0d", i), mon_q[i], {(i == 29), expd});
      end

      // Stop after three words, wait, start, finish the message
      mon_q.delete();
      send_words(32'h0000_0300, 32'h0000_0400, 0, 3, 5, "stop_send_a");
      ctl(3'd2, 2'd1, "stop_mid");
      repeat (10) tick();
      chk("stopped_in_busy", 65'(bus.wsiS0_SThreadBusy), 65'd1);
      wait_q(3, "stop_drained");
      ctl(3'd1, 2'd1, "restart");
      send_words(32'h0000_0300, 32'h0000_0400, 3, 3, 5, "stop_send_b");
      wait_q(6, "stop_out_count");
      for (int i = 0; i < 6 && i < mon_q.size(); i++) begin
         chk($sformatf("stop_w%0d", i), mon_q[i], {(i == 5), 32'h0000_0410 + 32'(i), 32'h0000_0310 + 32'(i)});
      end

      // Release mid-stream discards buffered data
      mon_q.delete();
      bus.wsiM0_SThreadBusy = 1'b1;
      send_words(32'h0000_0700, 32'h0000_0800, 0, 4, 9, "rel_send");
      tick();
      chk("rel_holding", 65'(bus.wsiM0_MCmd), 65'd1);
      ctl(3'd3, 2'd1, "release");
      chk("rel_out_cmd", 65'(resp_mcmd), 65'd0);
      bus.wsiM0_SThreadBusy = 1'b0;
      repeat (5) tick();
      chk("rel_nothing_out", 65'(mon_q.size()), 65'd0);
      chk("rel_in_busy", 65'(bus.wsiS0_SThreadBusy), 65'd1);
      prop_rd(8'h0C, 32'd40, "rel_word_cnt");
      prop_rd(8'h08, 32'd4, "rel_msg_cnt");

      // Restart: only new data appears
      ctl(3'd0, 2'd1, "reinit");
      ctl(3'd1, 2'd1, "restart2");
      put({32'h0000_0005, 32'h0000_0006}, 1'b1, 8'h33, 12'd1);
      tick();
      idle();
      wait_q(1, "post_rel_count");
      chk("post_rel_w0", mon_q[0], {1'b1, 32'h0000_0015, 32'h0000_0016});
      repeat (3) tick();
      chk("post_rel_single", 65'(mon_q.size()), 65'd1);
      prop_rd(8'h0C, 32'd41, "final_word_cnt");
      prop_rd(8'h08, 32'd5, "final_msg_cnt");

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

   // Absolute time bound for the whole run.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
